sat_schedule_sequencer: RTL
===========================

Name: sat_schedule_sequencer

Overview:
- Parametrised, table-driven successor to the fixed-schedule SAT pipeline controller.
- Steps a slot counter through a PIPELINE_DEPTH-slot round and emits one SIGNAL_WIDTH-bit control word per slot to the datapath.
- Words come from a run-time-loadable schedule table, not hard-coded constants.
- Adds start/stop handshake, stall, masked fill and drain rounds, round counting and configuration error reporting.

Parameters:
SIGNAL_WIDTH, 13, width of control word
PIPELINE_DEPTH, 12, slots per round (>=2)
FILL_MASK, 13'h1FFD, AND-mask applied during the first (fill) round; default clears bit 1 (fifo read enable)
DRAIN_MASK, 13'h0002, AND-mask applied during the drain round
IDLE_VALUE, 13'h0018, word driven when idle or stalled; also the table reset contents
ROUND_CNT_WIDTH, 16, width of the round counter

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  begin operation; sampled in IDLE only
stop_i  in  1  request stop; sticky until serviced
stall_i  in  1  freeze sequencing
cfg_we_i  in  1  schedule table write enable
cfg_addr_i  in  SW=max(1,$clog2(PIPELINE_DEPTH))  table slot to write
cfg_data_i  in  SIGNAL_WIDTH  table write data
control_signal_o  out  SIGNAL_WIDTH  registered control word
slot_o  out  SW  slot index matching control_signal_o
busy_o  out  1  high in FILL/RUN/DRAIN
round_done_o  out  1  one-cycle pulse on the last slot of a round
rounds_o  out  ROUND_CNT_WIDTH  completed rounds since last start, saturating
cfg_err_o  out  1  one-cycle pulse on a rejected cfg write

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; slot_o 0; control_signal_o IDLE_VALUE.
  - busy_o, round_done_o, cfg_err_o 0; rounds_o 0; stop_pending 0.
  - All table entries set to IDLE_VALUE.
- Reset mid-round aborts immediately with no drain.
- States: IDLE, FILL, RUN, DRAIN.
  - IDLE -> FILL on start_i.
  - FILL -> RUN at end of round if stop_pending=0; FILL -> DRAIN at end of round if stop_pending=1.
  - RUN -> RUN at end of round if stop_pending=0; RUN -> DRAIN at end of round if stop_pending=1.
  - DRAIN -> IDLE at end of round.
  - "End of round": an unstalled cycle in which slot_o = PIPELINE_DEPTH-1.
- Output timing:
  - control_signal_o and slot_o are registered together; the word always corresponds to the displayed slot.
  - Start accepted at edge N: slot 0 appears at edge N+1.
- Output word by state:
  - FILL: table[slot] & FILL_MASK.
  - RUN: table[slot].
  - DRAIN: table[slot] & DRAIN_MASK.
  - IDLE: IDLE_VALUE.
- Slot counter:
  - Increments by 1 per unstalled active cycle.
  - Wraps PIPELINE_DEPTH-1 -> 0; no other wrap even when PIPELINE_DEPTH is not a power of 2.
- Stall (active states only):
  - State and slot hold; control_signal_o = IDLE_VALUE.
  - round_done_o suppressed; the held slot is re-issued with its normal word when stall_i drops.
  - stall_i is ignored in IDLE.
- Stop:
  - stop_i in any active state sets stop_pending.
  - stop_pending is cleared on entry to DRAIN and while in IDLE.
  - stop_i asserted simultaneously with start_i in IDLE: start accepted and stop latched, so the sequence is FILL, DRAIN, IDLE (RUN skipped).
- start_i while busy: ignored.
- Rounds:
  - round_done_o is high in the cycle control_signal_o shows slot PIPELINE_DEPTH-1 (unstalled).
  - rounds_o increments on each end of round (FILL, RUN and DRAIN all count) and saturates at all-ones.
  - rounds_o clears to 0 when start is accepted.
- Configuration:
  - Writes are committed only in IDLE with cfg_addr_i < PIPELINE_DEPTH.
  - A write while busy, or to an out-of-range address, is dropped and pulses cfg_err_o the next cycle.
  - A write in the same cycle start is accepted is committed and visible to the first FILL slot.
- busy_o is registered and high exactly while state != IDLE.

Test Plan:
- Reset, load table[i]=i+1, pulse start_i -> FILL words (i+1)&13'h1FFD for slots 0..11, e.g. slot 1 = 13'h0000; then RUN slot 1 = 13'h0002; round_done_o high at slot 11; rounds_o=1 after FILL.
- Run 3 rounds, pulse stop_i at slot 4 of round 3 -> round 3 completes, DRAIN words table[i]&13'h0002, then IDLE with control_signal_o=13'h0018, busy_o=0, rounds_o=4.
- Assert stall_i 3 cycles at RUN slot 6 -> slot_o held at 6, control_signal_o=13'h0018 for 3 cycles, then slot 6 word reissued; round length becomes 15 cycles.
- Simultaneous start_i and stop_i in IDLE -> 12 FILL slots, 12 DRAIN slots, IDLE; rounds_o=2.
- cfg write addr 12 in IDLE, and addr 3 while in RUN -> both dropped with cfg_err_o pulses; table unchanged on readback via next FILL.
- Assert rst_ni low mid-RUN at slot 7 -> immediate IDLE outputs; table contents = 13'h0018 in all slots on next run.

Source files
------------

// File: rtl/sat_schedule_sequencer.sv
// Table-driven pipeline schedule sequencer: walks PIPELINE_DEPTH slots per round and
// emits a registered control word per slot, with fill/drain masking, stall and stop.
module sat_schedule_sequencer #(
    parameter int                      SIGNAL_WIDTH    = 13,
    parameter int                      PIPELINE_DEPTH  = 12,
    parameter logic [SIGNAL_WIDTH-1:0] FILL_MASK       = 13'h1FFD,
    parameter logic [SIGNAL_WIDTH-1:0] DRAIN_MASK      = 13'h0002,
    parameter logic [SIGNAL_WIDTH-1:0] IDLE_VALUE      = 13'h0018,
    parameter int                      ROUND_CNT_WIDTH = 16,
    localparam int                     SW = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       stall_i,
    input  logic                       cfg_we_i,
    input  logic [SW-1:0]              cfg_addr_i,
    input  logic [SIGNAL_WIDTH-1:0]    cfg_data_i,
    output logic [SIGNAL_WIDTH-1:0]    control_signal_o,
    output logic [SW-1:0]              slot_o,
    output logic                       busy_o,
    output logic                       round_done_o,
    output logic [ROUND_CNT_WIDTH-1:0] rounds_o,
    output logic                       cfg_err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_DRAIN} state_e;

    localparam logic [SW-1:0] LAST_SLOT = SW'(PIPELINE_DEPTH - 1);
    localparam logic [SW:0]   DEPTH     = (SW+1)'(PIPELINE_DEPTH);

    state_e                      r_state, w_state_nxt;
    logic [SW-1:0]               r_cnt;
    logic                        r_stop_pend;
    logic [SIGNAL_WIDTH-1:0]     r_table [PIPELINE_DEPTH];
    logic [SIGNAL_WIDTH-1:0]     r_ctrl;
    logic [SW-1:0]               r_slot;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_err;
    logic [ROUND_CNT_WIDTH-1:0]  r_rounds;

    logic                        w_active;
    logic                        w_start;
    logic                        w_issue;
    logic                        w_eor;
    logic                        w_stop;
    logic                        w_addr_ok;
    logic                        w_cfg_commit;
    logic                        w_cfg_err;
    logic [SIGNAL_WIDTH-1:0]     w_entry;
    logic [SIGNAL_WIDTH-1:0]     w_word;

    // r_cnt is the slot to issue next; slot_o/control_signal_o show the slot issued last edge.
    assign w_active     = (r_state != ST_IDLE);
    assign w_start      = !w_active && start_i;
    assign w_issue      = w_active && !stall_i;
    assign w_eor        = w_issue && (r_cnt == LAST_SLOT);
    assign w_stop       = r_stop_pend || stop_i;
    assign w_addr_ok    = ({1'b0, cfg_addr_i} < DEPTH);
    assign w_cfg_commit = cfg_we_i && !w_active && w_addr_ok;
    assign w_cfg_err    = cfg_we_i && !w_cfg_commit;
    assign w_entry      = r_table[r_cnt];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:         if (start_i) w_state_nxt = ST_FILL;
            ST_FILL, ST_RUN: if (w_eor)   w_state_nxt = w_stop ? ST_DRAIN : ST_RUN;
            ST_DRAIN:        if (w_eor)   w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_word = IDLE_VALUE;
        case (r_state)
            ST_FILL:  if (!stall_i) w_word = w_entry & FILL_MASK;
            ST_RUN:   if (!stall_i) w_word = w_entry;
            ST_DRAIN: if (!stall_i) w_word = w_entry & DRAIN_MASK;
            default:                w_word = IDLE_VALUE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            if (w_start)      r_cnt <= '0;
            else if (w_issue) r_cnt <= (r_cnt == LAST_SLOT) ? '0 : r_cnt + SW'(1);
            // A stop seen at end of round goes straight to DRAIN, so nothing stays pending.
            if (!w_active)    r_stop_pend <= start_i && stop_i;
            else              r_stop_pend <= w_eor ? 1'b0 : w_stop;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl   <= IDLE_VALUE;
            r_slot   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rounds <= '0;
        end else begin
            r_ctrl <= w_word;
            r_slot <= w_active ? r_cnt : '0;
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= w_eor;
            r_err  <= w_cfg_err;
            if (w_start)                      r_rounds <= '0;
            else if (w_eor && r_rounds != '1) r_rounds <= r_rounds + ROUND_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIPELINE_DEPTH; i++) r_table[i] <= IDLE_VALUE;
        end else if (w_cfg_commit) begin
            r_table[cfg_addr_i] <= cfg_data_i;
        end
    end

    assign control_signal_o = r_ctrl;
    assign slot_o           = r_slot;
    assign busy_o           = r_busy;
    assign round_done_o     = r_done;
    assign rounds_o         = r_rounds;
    assign cfg_err_o        = r_err;

endmodule
